interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  CPU-side end of the peripheral interrupt handshake.
//  - Collects BUS_INTERRUPT_RAISE levels from up to 8 peripherals (timer, mouse, ...) and applies a per-source enable mask.
//  - Picks the lowest-numbered enabled source, presents one request plus ID to the CPU, and returns a one-cycle
//    BUS_INTERRUPT_ACK pulse to that peripheral once the CPU acknowledges.
//  - Memory-mapped on the shared 8-bit bus.
// PARAMETERS
//  IntCtrlBaseAddr    8'hE0        base of 4-byte register window
//  NumSources         2            number of interrupt sources, 1..8
//  InitialEnable      8'hFF        enable mask after reset (bits >= NumSources ignored)
// PORTS
//  CLK                 in     1     system clock, single domain
//  RST                 in     1     synchronous, active-high reset
//  BUS_ADDR            in     8     bus address
//  BUS_DATA            inout  8     bus data, tristated unless this block is addressed
//  BUS_WE              in     1     bus write strobe
//  BUS_INTERRUPTS_RAISE in    N     level request per source, held by peripheral until acked
//  BUS_INTERRUPTS_ACK  out    N     one-cycle ack pulse per source
//  CPU_INTERRUPT       out    1     request to CPU
//  CPU_INTERRUPT_ID    out    3     index of the source being serviced
//  CPU_INTERRUPT_ACK   in     1     CPU accepts request, single-cycle pulse
// BEHAVIOUR
//  Reset
//   - Regs: CPU_INTERRUPT=0, CPU_INTERRUPT_ID=0, BUS_INTERRUPTS_ACK=0, enable=InitialEnable[N-1:0], state=IDLE.
//   - BUS_DATA=Z.
//   - Reset mid-handshake abandons it: no ack pulse is issued.
//  Register map (reads registered)
//   - BUS_DATA is driven the cycle after BUS_ADDR matches with BUS_WE=0.
//   - +0 R   pending = raise & enable, zero-extended to 8 bits; writes ignored.
//   - +1 RW  enable mask; write takes effect next cycle; bits >= N read 0.
//   - +2 R   {5'b0, CPU_INTERRUPT_ID}; writes ignored.
//   - +3 R   {7'b0, CPU_INTERRUPT}; writes ignored.
//  FSM: IDLE, REQ, ACK, GUARD
//   - IDLE : if |pending, latch ID = lowest set index, set CPU_INTERRUPT=1 -> REQ.
//            Request is visible 1 cycle after raise is sampled.
//   - REQ  : hold CPU_INTERRUPT and ID.
//            On CPU_INTERRUPT_ACK: CPU_INTERRUPT<=0, BUS_INTERRUPTS_ACK[ID]<=1 -> ACK.
//            Clearing enable[ID] or dropping raise[ID] while in REQ does not withdraw the request;
//            the CPU must still ack it.
//   - ACK  : ack pulse lasts exactly 1 cycle; BUS_INTERRUPTS_ACK<=0 -> GUARD.
//   - GUARD: one idle cycle so the peripheral's registered raise can drop -> IDLE.
//            A raise still high in IDLE afterwards is a new interrupt.
//  Priority and width rules
//   - Lowest index wins; ties are impossible.
//   - A higher-priority source arriving during REQ/ACK/GUARD waits for IDLE (no preemption).
//   - CPU_INTERRUPT_ACK outside REQ is ignored.
//   - Minimum spacing between two CPU requests: 3 cycles after the CPU ack.
//   - At most one bit of BUS_INTERRUPTS_ACK is high in any cycle.
//   - Bus write to +1 in the same cycle that IDLE samples pending: IDLE uses the old mask.
// STRUCTURE
//  Shared package/header:
//   - register offsets (PEND=0, EN=1, ID=2, STAT=3)
//   - FSM state encoding (2 bits)
//   - max source count 8
//  Sub-module: int_priority_encoder (N-bit vector -> 3-bit lowest-set index + valid), purely combinational.
//  Everything else (FSM, registers, tristate) lives in this module.
// TESTING
//  1. Reset, then read +1 and +2 -> 8'h03 (N=2) and 8'h00; CPU_INTERRUPT=0, BUS_DATA=Z when unaddressed.
//  2. raise=2'b10 at t -> CPU_INTERRUPT=1, ID=1 at t+1; CPU ack at t+4 -> BUS_INTERRUPTS_ACK=2'b10 at t+5 only,
//     CPU_INTERRUPT=0 at t+5.
//  3. raise=2'b11 together -> ID=0 serviced first; source 1 is raised to CPU 3 cycles after the source-0 ack
//     pulse (GUARD, then IDLE).
//  4. Write 8'h01 to +1, raise source 1 -> no CPU_INTERRUPT, +0 reads 8'h00; re-enable with 8'h03 ->
//     request 2 cycles after the write.
//  5. Assert RST while in REQ -> next cycle CPU_INTERRUPT=0, no ack pulse issued, enable=8'h03.
//  6. Peripheral re-raises in the same cycle as the ack (timer target coincident) -> second request issued
//     after GUARD; no lost or duplicated ack.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM encoding, source limits.
// Pure declarations; no timing or flow-control content.
package interrupt_controller_pkg;

  localparam int MaxSources = 8;
  localparam int IdW        = $clog2(MaxSources);

  localparam logic [1:0] RegPend = 2'd0;
  localparam logic [1:0] RegEn   = 2'd1;
  localparam logic [1:0] RegId   = 2'd2;
  localparam logic [1:0] RegStat = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACK   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

endpackage

// File: rtl/int_priority_encoder.sv
// Lowest-set-bit index of a request vector plus an any-set flag.
// Combinational, zero latency; no flow control.
module int_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int Width = 2
) (
  input  logic [Width-1:0] req,
  output logic [IdW-1:0]   idx,
  output logic             vld
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req[i]) idx = IdW'(i);
    end
  end

  assign vld = |req;

endmodule

// File: rtl/interrupt_controller.sv
// CPU-side interrupt handshake: masks peripheral raises, requests the CPU one cycle after sampling,
// returns a single-cycle ack to the serviced source; bus reads answer one cycle after the address.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [7:0] IntCtrlBaseAddr = 8'hE0,
  parameter int         NumSources      = 2,
  parameter logic [7:0] InitialEnable   = 8'hFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            BUS_ADDR,
  inout  wire  [7:0]            BUS_DATA,
  input  logic                  BUS_WE,
  input  logic [NumSources-1:0] BUS_INTERRUPTS_RAISE,
  output logic [NumSources-1:0] BUS_INTERRUPTS_ACK,
  output logic                  CPU_INTERRUPT,
  output logic [IdW-1:0]        CPU_INTERRUPT_ID,
  input  logic                  CPU_INTERRUPT_ACK
);

  state_t                state, state_nxt;
  logic [NumSources-1:0] enable;
  logic [NumSources-1:0] pending;
  logic [NumSources-1:0] ack_nxt;
  logic [IdW-1:0]        win_idx, id_nxt;
  logic                  win_vld, cpu_int_nxt;
  logic [7:0]            addr_off;
  logic                  addr_hit;
  logic [7:0]            rd_mux, rd_data;
  logic                  rd_en;

  assign pending  = BUS_INTERRUPTS_RAISE & enable;
  assign addr_off = BUS_ADDR - IntCtrlBaseAddr;
  assign addr_hit = (addr_off < 8'd4);

  int_priority_encoder #(.Width(NumSources)) u_prio (
    .req (pending),
    .idx (win_idx),
    .vld (win_vld)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (win_vld) state_nxt = ST_REQ;
      ST_REQ:   if (CPU_INTERRUPT_ACK) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_GUARD;
      ST_GUARD: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Once in REQ the latched ID is serviced even if its enable or raise disappears.
  always_comb begin
    cpu_int_nxt = CPU_INTERRUPT;
    id_nxt      = CPU_INTERRUPT_ID;
    ack_nxt     = '0;
    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          cpu_int_nxt = 1'b1;
          id_nxt      = win_idx;
        end
      end
      ST_REQ: begin
        if (CPU_INTERRUPT_ACK) begin
          cpu_int_nxt = 1'b0;
          for (int i = 0; i < NumSources; i++) begin
            ack_nxt[i] = (CPU_INTERRUPT_ID == IdW'(i));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CPU_INTERRUPT      <= 1'b0;
      CPU_INTERRUPT_ID   <= '0;
      BUS_INTERRUPTS_ACK <= '0;
    end else begin
      CPU_INTERRUPT      <= cpu_int_nxt;
      CPU_INTERRUPT_ID   <= id_nxt;
      BUS_INTERRUPTS_ACK <= ack_nxt;
    end
  end

  always_comb begin
    logic [MaxSources-1:0] pend_ext, en_ext;
    pend_ext                   = '0;
    en_ext                     = '0;
    pend_ext[NumSources-1:0]   = pending;
    en_ext[NumSources-1:0]     = enable;
    unique case (addr_off[1:0])
      RegPend: rd_mux = pend_ext;
      RegEn:   rd_mux = en_ext;
      RegId:   rd_mux = 8'(CPU_INTERRUPT_ID);
      RegStat: rd_mux = 8'(CPU_INTERRUPT);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enable  <= InitialEnable[NumSources-1:0];
      rd_en   <= 1'b0;
      rd_data <= '0;
    end else begin
      if (BUS_WE && addr_hit && (addr_off[1:0] == RegEn)) begin
        enable <= BUS_DATA[NumSources-1:0];
      end
      rd_en   <= addr_hit && !BUS_WE;
      rd_data <= rd_mux;
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised scoreboard bench for interrupt_controller (2 sources, base 8'hE0).
module tb_interrupt_controller;

  localparam logic [7:0] Base = 8'hE0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;
  logic       bus_we;
  logic [1:0] raise;
  logic [1:0] ack;
  logic       cpu_int;
  logic [2:0] cpu_id;
  logic       cpu_ack;
  logic       tb_drv;
  logic [7:0] tb_wd;

  assign bus_data = tb_drv ? tb_wd : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (bus_data[gi]);
  end

  always #5 clk = ~clk;

  interrupt_controller #(
    .IntCtrlBaseAddr (Base),
    .NumSources      (2),
    .InitialEnable   (8'hFF)
  ) dut (
    .CLK                  (clk),
    .RST                  (rst),
    .BUS_ADDR             (bus_addr),
    .BUS_DATA             (bus_data),
    .BUS_WE               (bus_we),
    .BUS_INTERRUPTS_RAISE (raise),
    .BUS_INTERRUPTS_ACK   (ack),
    .CPU_INTERRUPT        (cpu_int),
    .CPU_INTERRUPT_ID     (cpu_id),
    .CPU_INTERRUPT_ACK    (cpu_ack)
  );

  typedef struct {
    int         tag;
    logic [7:0] val;
  } ev_t;

  ev_t req_q[$];
  ev_t ack_q[$];
  ev_t rd_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: enable mask, outstanding request, serviced ID, first edge allowed to sample.
  logic [1:0] m_en;
  logic       m_req;
  logic [2:0] m_id;
  int         m_free;
  logic       last_rd;
  logic       mon_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [1:0] v);
    return v[0] ? 3'd0 : 3'd1;
  endfunction

  // Applies one cycle of inputs before edge cyc+1 and predicts what that edge produces.
  task automatic step(input logic r, input logic [1:0] rs, input logic ca,
                      input int op, input logic [7:0] a, input logic [7:0] wd);
    logic [7:0] off;
    logic [7:0] rv;
    ev_t        e;
    int         tag;
    @(negedge clk);
    #1;
    if (op == 2 && last_rd) op = 0;
    rst      = r;
    raise    = rs;
    cpu_ack  = ca;
    bus_addr = (op != 0) ? a : 8'h00;
    bus_we   = (op == 2);
    tb_drv   = (op == 2);
    tb_wd    = wd;
    tag      = cyc + 1;
    off      = a - Base;
    if (r) begin
      m_req   = 1'b0;
      m_id    = 3'd0;
      m_en    = 2'b11;
      m_free  = tag + 1;
      last_rd = 1'b0;
    end else begin
      if (op == 1) begin
        case (off)
          8'd0:    rv = {6'b0, rs & m_en};
          8'd1:    rv = {6'b0, m_en};
          8'd2:    rv = {5'b0, m_id};
          8'd3:    rv = {7'b0, m_req};
          default: rv = 8'hFF;
        endcase
        e.tag = tag; e.val = rv; rd_q.push_back(e);
      end
      if (m_req) begin
        if (ca) begin
          e.tag = tag; e.val = {6'b0, 2'b01 << m_id}; ack_q.push_back(e);
          m_req  = 1'b0;
          m_free = tag + 3;
        end
      end else if (tag >= m_free && (rs & m_en) != 2'b00) begin
        m_id  = lowest(rs & m_en);
        m_req = 1'b1;
        e.tag = tag; e.val = {5'b0, m_id}; req_q.push_back(e);
      end
      if (op == 2 && off == 8'd1) m_en = wd[1:0];
      last_rd = (op == 1);
    end
  endtask

  // Monitor: outputs of edge cyc are stable at the following negedge.
  initial begin
    ev_t e;
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      chk("cpu_int_level", {31'b0, cpu_int}, {31'b0, m_req});
      chk("cpu_id_level", {29'b0, cpu_id}, {29'b0, m_id});
      if (req_q.size() > 0 && req_q[0].tag == cyc) begin
        e = req_q.pop_front();
        chk("req_rise", {31'b0, cpu_int & ~mon_prev}, 32'd1);
        chk("req_id", {29'b0, cpu_id}, {29'b0, e.val[2:0]});
      end else begin
        chk("no_new_req", {31'b0, cpu_int & ~mon_prev}, 32'd0);
      end
      if (ack_q.size() > 0 && ack_q[0].tag == cyc) begin
        e = ack_q.pop_front();
        chk("ack_pulse", {30'b0, ack}, {24'b0, e.val});
      end else begin
        chk("ack_quiet", {30'b0, ack}, 32'd0);
      end
      if (rd_q.size() > 0 && rd_q[0].tag == cyc) begin
        e = rd_q.pop_front();
        chk("bus_read", {24'b0, bus_data}, {24'b0, e.val});
      end
      mon_prev = cpu_int;
    end
  end

  initial begin
    logic [1:0] per;
    logic       ca, r;
    int         op, sel;
    logic [7:0] a, wd;

    rst = 1'b1; raise = '0; cpu_ack = 1'b0; bus_addr = '0; bus_we = 1'b0;
    tb_drv = 1'b0; tb_wd = '0;
    m_en = 2'b11; m_req = 1'b0; m_id = 3'd0; m_free = 0; last_rd = 1'b0;

    // Reset state and register reads, unaddressed bus floats.
    step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 1, Base + 8'd1, 0);
    step(0, 2'b00, 0, 1, Base + 8'd2, 0);
    step(0, 2'b00, 0, 1, 8'h10, 0);
    step(0, 2'b00, 0, 0, 0, 0);

    // Single source 1 request and ack.
    repeat (4) step(0, 2'b10, 0, 0, 0, 0);
    step(0, 2'b10, 1, 0, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);

    // Both raised: source 0 first, source 1 after the guard.
    repeat (3) step(0, 2'b11, 0, 0, 0, 0);
    step(0, 2'b11, 1, 1, Base + 8'd2, 0);
    repeat (5) step(0, 2'b10, 0, 0, 0, 0);
    step(0, 2'b10, 1, 0, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);

    // Masked source, pending read, re-enable.
    step(0, 2'b00, 0, 2, Base + 8'd1, 8'h01);
    repeat (3) step(0, 2'b10, 0, 0, 0, 0);
    step(0, 2'b10, 0, 1, Base, 0);
    step(0, 2'b10, 0, 0, 0, 0);
    step(0, 2'b10, 0, 2, Base + 8'd1, 8'h03);
    repeat (3) step(0, 2'b10, 0, 1, Base + 8'd3, 0);
    step(0, 2'b10, 1, 0, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);

    // Reset while a request is outstanding, with a coincident CPU ack.
    step(0, 2'b00, 0, 2, Base + 8'd1, 8'h02);
    repeat (3) step(0, 2'b10, 0, 0, 0, 0);
    step(1, 2'b10, 1, 0, 0, 0);
    step(0, 2'b00, 0, 1, Base + 8'd1, 0);
    repeat (3) step(0, 2'b00, 0, 0, 0, 0);

    // Peripheral keeps raise high across its ack: a second request follows the guard.
    repeat (2) step(0, 2'b01, 0, 0, 0, 0);
    step(0, 2'b01, 1, 0, 0, 0);
    repeat (5) step(0, 2'b01, 0, 0, 0, 0);
    step(0, 2'b01, 1, 0, 0, 0);
    repeat (4) step(0, 2'b00, 0, 0, 0, 0);

    // Randomised traffic: peripherals hold until acked, CPU acks at random.
    per = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ack[i] && $urandom_range(0, 3) != 0) per[i] = 1'b0;
        if (!per[i] && $urandom_range(0, 3) == 0) per[i] = 1'b1;
      end
      ca  = cpu_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 299) == 0);
      sel = $urandom_range(0, 9);
      a   = 8'h00;
      wd  = 8'($urandom);
      op  = 0;
      if (sel < 2) begin
        op = 1; a = Base + 8'($urandom_range(0, 3));
      end else if (sel == 2) begin
        op = 1; a = Base + 8'($urandom_range(4, 11));
      end else if (sel == 3) begin
        op = 2; a = Base + 8'($urandom_range(0, 3));
      end
      if (r) op = 0;
      step(r, per, ca, op, a, wd);
    end

    // Drain: no new raises, CPU acks whatever is outstanding.
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      step(0, 2'b00, cpu_int, 0, 0, 0);
    end
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("req_queue_empty", req_q.size(), 0);
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
